mem_region_router: RTL and testbench

Parametrised data-port router between the core's load/store port and NUM_CH memory-mapped slave channels. It replaces the fixed two-way memory/MMIO split with a registered request FSM. Each access is latched, decoded against per-channel base/mask regions, issued with a valid/ready handshake, and completed on the selected channel's response. Unmapped addresses and response timeouts produce an error pulse to the core instead of a hang.

---
 rtl/mem_region_router.sv | 169 ++++++++++++++++
 tb/tb_mem_region_router.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_region_router.sv
// Routes the core's load/store port to one of NUM_CH memory-mapped slave channels
// through a registered IDLE/ISSUE/WAIT/DONE request FSM with decode and timeout errors.
module mem_region_router #(
  parameter int                            NUM_CH      = 2,
  parameter int                            ADDR_WIDTH  = 64,
  parameter int                            DATA_WIDTH  = 64,
  parameter logic [NUM_CH*ADDR_WIDTH-1:0]  REGION_BASE = {64'h1000_0000, 64'h8000_0000},
  parameter logic [NUM_CH*ADDR_WIDTH-1:0]  REGION_MASK = {64'hFFFF_FFFF_F000_0000,
                                                          64'hFFFF_FFFF_8000_0000},
  parameter int                            TIMEOUT     = 256
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         cpu_ren,
  input  logic                         cpu_wen,
  input  logic [ADDR_WIDTH-1:0]        cpu_addr,
  input  logic [DATA_WIDTH-1:0]        cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0]      cpu_wmask,
  output logic [DATA_WIDTH-1:0]        cpu_rdata,
  output logic                         cpu_stall,
  output logic                         cpu_err,
  output logic [NUM_CH-1:0]            ch_req_valid,
  input  logic [NUM_CH-1:0]            ch_req_ready,
  output logic                         ch_we,
  output logic [ADDR_WIDTH-1:0]        ch_addr,
  output logic [DATA_WIDTH-1:0]        ch_wdata,
  output logic [DATA_WIDTH/8-1:0]      ch_wmask,
  input  logic [NUM_CH-1:0]            ch_resp_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata,
  input  logic [NUM_CH-1:0]            ch_resp_err
);

  localparam int MW = DATA_WIDTH / 8;
  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MW-1:0]         wmask_q, wmask_d;

  logic                  req;
  logic                  hit;
  logic [SW-1:0]         hit_idx;
  logic                  timeout_hit;

  assign req = cpu_ren | cpu_wen;

  // Scanning from the top down lets the lowest matching index overwrite the others.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if ((cpu_addr & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d = state_q;
    sel_d   = sel_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    unique case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (req) begin
          we_d    = cpu_wen;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          wmask_d = cpu_wmask;
          if (hit && !(cpu_ren && cpu_wen)) begin
            sel_d   = hit_idx;
            err_d   = 1'b0;
            state_d = S_ISSUE;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        tmo_d = tmo_q + TW'(1);
        if (timeout_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_DONE;
        end else if (ch_req_ready[sel_q]) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        // A response completing on the last allowed cycle beats the timeout.
        if (ch_resp_valid[sel_q]) begin
          err_d   = ch_resp_err[sel_q];
          rdata_d = (we_q || ch_resp_err[sel_q]) ? '0 : ch_rdata[sel_q*DATA_WIDTH +: DATA_WIDTH];
          state_d = S_DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  always_comb begin
    ch_req_valid = '0;
    if (state_q == S_ISSUE) ch_req_valid[sel_q] = 1'b1;
  end

  // Gating with rstn keeps stall low while reset holds the FSM even if a request is pending.
  assign cpu_stall = rstn & (((state_q == S_IDLE) & req) |
                             (state_q == S_ISSUE) | (state_q == S_WAIT));
  assign cpu_err   = (state_q == S_DONE) & err_q;
  assign cpu_rdata = rdata_q;
  assign ch_we     = we_q;
  assign ch_addr   = addr_q;
  assign ch_wdata  = wdata_q;
  assign ch_wmask  = wmask_q;

endmodule

// File: tb/tb_mem_region_router.sv
// Directed bench for mem_region_router: a per-access timeline model predicts every
// cycle's outputs, and a negedge compare process checks the DUT against it.
module tb_mem_region_router;

  localparam int NCH = 2;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int MW  = 8;
  localparam int TMO = 8;
  localparam logic [DW-1:0] JUNK = 64'hBAD0_0000_BAD0_0000;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                cpu_ren = 1'b0, cpu_wen = 1'b0;
  logic [AW-1:0]       cpu_addr = '0;
  logic [DW-1:0]       cpu_wdata = '0;
  logic [MW-1:0]       cpu_wmask = '0;
  logic [DW-1:0]       cpu_rdata;
  logic                cpu_stall, cpu_err;
  logic [NCH-1:0]      ch_req_valid;
  logic [NCH-1:0]      ch_req_ready = '0;
  logic                ch_we;
  logic [AW-1:0]       ch_addr;
  logic [DW-1:0]       ch_wdata;
  logic [MW-1:0]       ch_wmask;
  logic [NCH-1:0]      ch_resp_valid = '0;
  logic [NCH*DW-1:0]   ch_rdata = '0;
  logic [NCH-1:0]      ch_resp_err = '0;

  always #5 clk = ~clk;

  mem_region_router #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
    .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_wmask(ch_wmask),
    .ch_resp_valid(ch_resp_valid), .ch_rdata(ch_rdata), .ch_resp_err(ch_resp_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs, written by the stimulus and read by the compare process.
  logic           chk_en = 1'b0;
  logic           e_stall = 1'b0, e_err = 1'b0, e_we = 1'b0;
  logic [NCH-1:0] e_valid = '0;
  logic [AW-1:0]  e_addr = '0;
  logic [DW-1:0]  e_wdata = '0;
  logic [MW-1:0]  e_wmask = '0;
  logic [DW-1:0]  m_rdata = '0;
  int             n_stall, n_v0, n_v1, n_err;

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 64'(cpu_stall), 64'(e_stall));
      check("req_valid", 64'(ch_req_valid), 64'(e_valid));
      check("err", 64'(cpu_err), 64'(e_err));
      check("rdata", cpu_rdata, m_rdata);
      if (e_valid != '0) begin
        check("ch_addr", ch_addr, e_addr);
        check("ch_wdata", ch_wdata, e_wdata);
        check("ch_wmask", 64'(ch_wmask), 64'(e_wmask));
        check("ch_we", 64'(ch_we), 64'(e_we));
      end
      n_stall += int'(cpu_stall);
      n_v0    += int'(ch_req_valid[0]);
      n_v1    += int'(ch_req_valid[1]);
      n_err   += int'(cpu_err);
    end
  end

  // Region map: lowest index wins.
  function automatic int decode(input logic [AW-1:0] a);
    if ((a & 64'hFFFF_FFFF_8000_0000) == 64'h8000_0000) return 0;
    if ((a & 64'hFFFF_FFFF_F000_0000) == 64'h1000_0000) return 1;
    return -1;
  endfunction

  task automatic clear_inputs();
    ch_req_ready  = '0;
    ch_resp_valid = '0;
    ch_resp_err   = '0;
    ch_rdata      = {NCH{JUNK}};
  endtask

  // One access: request held through DONE; slave accepts after rdy_dly ISSUE cycles and
  // answers on the rsp_dly-th WAIT cycle. junk adds ignorable responses in ISSUE/WAIT.
  task automatic access(input bit ren, input bit wen, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [MW-1:0] wmask,
                        input int rdy_dly, input int rsp_dly, input bit noresp,
                        input bit rsp_err, input logic [DW-1:0] srdata, input bit junk);
    int ch, busy, n_iss, resp_t;
    bit err;
    logic [DW-1:0] rd;
    ch = (ren && wen) ? -1 : decode(addr);
    if (ch < 0) begin
      busy = 0; n_iss = 0; resp_t = -1; err = 1'b1; rd = '0;
    end else begin
      n_iss  = rdy_dly + 1;
      resp_t = n_iss + rsp_dly;
      busy   = resp_t;
      err    = rsp_err;
      rd     = (wen || rsp_err) ? '0 : srdata;
      if (noresp || busy > TMO) begin
        busy = TMO; err = 1'b1; rd = '0;
        if (n_iss > TMO) n_iss = TMO;
      end
    end
    n_stall = 0; n_v0 = 0; n_v1 = 0; n_err = 0;
    for (int t = 0; t <= busy + 1; t++) begin
      cpu_ren = ren; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata; cpu_wmask = wmask;
      clear_inputs();
      if (ch >= 0) begin
        if (t == rdy_dly + 1) ch_req_ready[ch] = 1'b1;
        if (!noresp && t == resp_t) begin
          ch_resp_valid[ch] = 1'b1;
          ch_resp_err[ch]   = rsp_err;
          ch_rdata[ch*DW +: DW] = srdata;
        end
        if (junk && t >= 1 && t <= n_iss) begin
          ch_resp_valid[ch] = 1'b1;
          ch_resp_err[ch]   = 1'b1;
        end
        if (junk && t > n_iss && t < resp_t) begin
          ch_resp_valid[1-ch] = 1'b1;
          ch_resp_err[1-ch]   = 1'b1;
        end
      end
      e_stall = (t <= busy);
      e_err   = (t == busy + 1) && err;
      e_valid = (ch >= 0 && t >= 1 && t <= n_iss) ? (NCH'(1) << ch) : '0;
      e_we = wen; e_addr = addr; e_wdata = wdata; e_wmask = wmask;
      if (t == busy + 1) m_rdata = rd;
      @(posedge clk); #1;
    end
    cpu_ren = 1'b0; cpu_wen = 1'b0;
    clear_inputs();
    e_stall = 1'b0; e_err = 1'b0; e_valid = '0;
  endtask

  task automatic idle_cyc(input bit late_resp);
    clear_inputs();
    if (late_resp) begin
      ch_resp_valid = '1;
      ch_resp_err   = '1;
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  // Starts a ch0 load, then pulls rstn low mid-cycle in ISSUE or WAIT.
  task automatic mid_reset(input bit to_wait);
    chk_en = 1'b0;
    clear_inputs();
    cpu_ren = 1'b1; cpu_wen = 1'b0; cpu_addr = 64'h8000_0040; cpu_wdata = '0; cpu_wmask = '0;
    @(posedge clk); #1;
    if (to_wait) begin
      ch_req_ready = 2'b01;
      @(posedge clk); #1;
      ch_req_ready = '0;
      check("rst_pre_wait_valid", 64'(ch_req_valid), 64'h0);
    end else begin
      check("rst_pre_issue_valid", 64'(ch_req_valid), 64'h1);
    end
    #2 rstn = 1'b0;
    #1;
    check("rst_valid", 64'(ch_req_valid), 64'h0);
    check("rst_stall", 64'(cpu_stall), 64'h0);
    check("rst_err", 64'(cpu_err), 64'h0);
    check("rst_rdata", cpu_rdata, 64'h0);
    check("rst_addr", ch_addr, 64'h0);
    check("rst_wmask", 64'(ch_wmask), 64'h0);
    check("rst_we", 64'(ch_we), 64'h0);
    cpu_ren = 1'b0;
    @(posedge clk); #1;
    ch_resp_valid = 2'b01;
    ch_rdata      = {NCH{JUNK}};
    @(posedge clk); #1;
    m_rdata = '0; e_stall = 1'b0; e_err = 1'b0; e_valid = '0;
    rstn   = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    cpu_ren = 1'b1;
    cpu_addr = 64'h8000_0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", 64'(cpu_stall), 64'h0);
    check("reset_valid", 64'(ch_req_valid), 64'h0);
    check("reset_rdata", cpu_rdata, 64'h0);
    check("reset_err", 64'(cpu_err), 64'h0);
    check("reset_wdata", ch_wdata, 64'h0);
    cpu_ren = 1'b0;
    rstn    = 1'b1;
    chk_en  = 1'b1;
    @(posedge clk); #1;

    // Best-case load to ch0.
    access(1, 0, 64'h8000_0010, '0, '0, 0, 1, 0, 0, 64'hDEAD_BEEF, 0);
    check("t1_stall_cycles", 64'(n_stall), 64'd3);
    check("t1_ch0_valid_cycles", 64'(n_v0), 64'd1);
    check("t1_ch1_valid_cycles", 64'(n_v1), 64'd0);
    check("t1_rdata", cpu_rdata, 64'hDEAD_BEEF);

    // Back-to-back store to ch1 with ready delayed 5 cycles.
    access(0, 1, 64'h1000_0008, 64'h55, 8'h01, 5, 1, 0, 0, 64'h1234, 0);
    check("t2_ch1_valid_cycles", 64'(n_v1), 64'd6);
    check("t2_rdata", cpu_rdata, 64'h0);

    // Unmapped load.
    idle_cyc(0);
    access(1, 0, 64'h0000_0004, '0, '0, 0, 1, 0, 0, '0, 0);
    check("t3_stall_cycles", 64'(n_stall), 64'd1);
    check("t3_err_cycles", 64'(n_err), 64'd1);
    check("t3_valid_cycles", 64'(n_v0 + n_v1), 64'd0);

    // Load and store asserted together.
    access(1, 1, 64'h8000_0000, 64'h77, 8'hFF, 0, 1, 0, 0, 64'h99, 0);

    // Response on the last allowed cycle completes; one cycle later times out.
    access(1, 0, 64'h8000_0020, '0, '0, 3, 4, 0, 0, 64'hCAFE_F00D, 0);
    check("edge_rdata", cpu_rdata, 64'hCAFE_F00D);
    access(1, 0, 64'h8000_0028, '0, '0, 3, 5, 0, 0, 64'h1111, 0);

    // ch0 accepts but never answers.
    access(1, 0, 64'h8000_0100, '0, '0, 0, 1, 1, 0, '0, 0);
    check("t4_stall_cycles", 64'(n_stall), 64'd9);
    check("t4_err_cycles", 64'(n_err), 64'd1);
    idle_cyc(1);
    access(1, 0, 64'h8000_0008, '0, '0, 0, 2, 0, 0, 64'h0123_4567_89AB_CDEF, 1);
    check("t4_next_rdata", cpu_rdata, 64'h0123_4567_89AB_CDEF);

    // ch1 slave error with stray ch0 response during WAIT.
    access(1, 0, 64'h1000_0000, '0, '0, 1, 2, 0, 1, 64'hFFFF_0000, 1);
    check("t5_err_cycles", 64'(n_err), 64'd1);
    check("t5_rdata", cpu_rdata, 64'h0);

    access(1, 0, 64'h8000_0030, '0, '0, 0, 1, 0, 0, 64'h4242, 0);
    access(0, 1, 64'h8000_0038, 64'hA5A5_5A5A, 8'hF0, 2, 3, 0, 0, 64'h3333, 0);

    // Resets mid-access, then a clean load.
    access(1, 0, 64'h8000_0030, '0, '0, 0, 1, 0, 0, 64'h7777, 0);
    mid_reset(0);
    access(1, 0, 64'h8000_0050, '0, '0, 0, 1, 0, 0, 64'h5050, 0);
    mid_reset(1);
    access(1, 0, 64'h8000_0018, '0, '0, 0, 1, 0, 0, 64'h0BAD_F00D, 0);
    check("t6_stall_cycles", 64'(n_stall), 64'd3);
    check("t6_rdata", cpu_rdata, 64'h0BAD_F00D);

    idle_cyc(0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
